// File: rtl/life_sequencer.sv
// Sequences the Life engines: a generation timer or step request waits for the vsync window,
// then runs INIT (reseed) or UPDATE followed by COPY. Optional phase watchdog: LIFE_SEQ_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | counting toward the next generation, or waiting for a step request
// WAIT_VS | generation due, holding until the vsync window opens
// INIT    | board reseed engine running
// UPDATE  | next-generation compute engine running
// COPY    | new generation being copied back to the display board
module life_sequencer #(
  parameter int unsigned CLOCK_FREQ  = 24000000,
  parameter int unsigned WDOG_CYCLES = 32768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step,
  input  logic        randomize,
  input  logic [1:0]  speed,
  input  logic        vsync,
  input  logic        init_done,
  input  logic        update_done,
  input  logic        copy_done,
  output logic        init_start,
  output logic        update_start,
  output logic        copy_start,
  output logic        busy,
  output logic [2:0]  state,
  output logic [15:0] gen_count,
  output logic        error
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_VS = 3'd1,
    ST_INIT    = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_COPY    = 3'd4
  } state_e;

  localparam logic [31:0] INTERVAL_2HZ  = 32'(CLOCK_FREQ / 32'd2);
  localparam logic [31:0] INTERVAL_5HZ  = 32'(CLOCK_FREQ / 32'd5);
  localparam logic [31:0] INTERVAL_10HZ = 32'(CLOCK_FREQ / 32'd10);
  localparam logic [31:0] INTERVAL_20HZ = 32'(CLOCK_FREQ / 32'd20);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] gen_count_q, gen_count_d;
  logic        first_q, first_d;
  logic [31:0] interval;
  logic [31:0] limit;

  // Rate is decoded live so a speed change lands on the very next comparison.
  always_comb begin
    interval = INTERVAL_2HZ;
    case (speed)
      2'd0:    interval = INTERVAL_2HZ;
      2'd1:    interval = INTERVAL_5HZ;
      2'd2:    interval = INTERVAL_10HZ;
      default: interval = INTERVAL_20HZ;
    endcase
  end

  assign limit = (interval == 32'd0) ? 32'd0 : interval - 32'd1;

`ifdef LIFE_SEQ_WATCHDOG_EN
  logic [31:0] phase_cnt_q, phase_cnt_d;
  logic        error_q, error_d;
  logic        in_phase;
  logic        wdog_hit;

  assign in_phase = (state_q == ST_INIT) || (state_q == ST_UPDATE) || (state_q == ST_COPY);
  assign wdog_hit = in_phase && (phase_cnt_q >= WDOG_CYCLES - 32'd1);
`endif

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    gen_count_d = gen_count_q;
`ifdef LIFE_SEQ_WATCHDOG_EN
    error_d     = error_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          if (timer_q >= limit) begin
            state_d = ST_WAIT_VS;
            timer_d = 32'd0;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end else begin
          timer_d = 32'd0;
          if (step) state_d = ST_WAIT_VS;
        end
      end
      ST_WAIT_VS: begin
        if (vsync) state_d = randomize ? ST_INIT : ST_UPDATE;
      end
      ST_INIT: begin
        if (init_done) begin
          state_d     = ST_IDLE;
          gen_count_d = 16'd0;
        end
      end
      ST_UPDATE: begin
        if (update_done) state_d = ST_COPY;
      end
      ST_COPY: begin
        if (copy_done) begin
          state_d     = ST_IDLE;
          gen_count_d = gen_count_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef LIFE_SEQ_WATCHDOG_EN
    // A done accepted in the same cycle wins over the timeout.
    if (wdog_hit && (state_d == state_q)) begin
      state_d = ST_IDLE;
      error_d = 1'b1;
    end
`endif

    first_d = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      timer_q     <= 32'd0;
      gen_count_q <= 16'd0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      gen_count_q <= gen_count_d;
      first_q     <= first_d;
    end
  end

`ifdef LIFE_SEQ_WATCHDOG_EN
  always_comb begin
    phase_cnt_d = phase_cnt_q;
    if (state_d != state_q) begin
      phase_cnt_d = 32'd0;
    end else if (in_phase) begin
      phase_cnt_d = phase_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_cnt_q <= 32'd0;
      error_q     <= 1'b0;
    end else begin
      phase_cnt_q <= phase_cnt_d;
      error_q     <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Gating with rst_n keeps the boot init_start out of the reset window itself.
  assign init_start   = rst_n && first_q && (state_q == ST_INIT);
  assign update_start = rst_n && first_q && (state_q == ST_UPDATE);
  assign copy_start   = rst_n && first_q && (state_q == ST_COPY);

  assign busy      = (state_q != ST_IDLE);
  assign state     = state_q;
  assign gen_count = gen_count_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer: behavioural model compared every cycle plus literal checkpoints.
module tb_life_sequencer;
  localparam int unsigned CF = 2000;
  localparam int unsigned WD = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0, step = 1'b0, randomize = 1'b0, vsync = 1'b0;
  logic        init_done = 1'b0, update_done = 1'b0, copy_done = 1'b0;
  logic [1:0]  speed = 2'd0;
  logic        init_start, update_start, copy_start, busy, error;
  logic [2:0]  state;
  logic [15:0] gen_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  life_sequencer #(.CLOCK_FREQ(CF), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .randomize(randomize),
    .speed(speed), .vsync(vsync), .init_done(init_done), .update_done(update_done),
    .copy_done(copy_done), .init_start(init_start), .update_start(update_start),
    .copy_start(copy_start), .busy(busy), .state(state), .gen_count(gen_count),
    .error(error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: phase = 0 idle,1 wait vsync,2 init,3 update,4 copy; age = cycles spent in the current phase.
  int          m_state = 2;
  int          m_age = 0;
  longint      m_idle = 0;
  int          m_gen = 0;
  bit          m_err = 1'b0;
  int          nxt;
  int unsigned rate [4] = '{2, 5, 10, 20};

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = 2;
      m_age   = 0;
      m_idle  = 0;
      m_gen   = 0;
      m_err   = 1'b0;
    end else begin
      nxt = m_state;
      if (m_state == 0) begin
        if (run) begin
          if (m_idle + 1 >= longint'(CF / rate[speed])) begin
            nxt = 1;
            m_idle = 0;
          end else begin
            m_idle = m_idle + 1;
          end
        end else begin
          m_idle = 0;
          if (step) nxt = 1;
        end
      end else if (m_state == 1) begin
        if (vsync) nxt = randomize ? 2 : 3;
      end else if (m_state == 2 && init_done) begin
        nxt = 0;
        m_gen = 0;
      end else if (m_state == 3 && update_done) begin
        nxt = 4;
      end else if (m_state == 4 && copy_done) begin
        nxt = 0;
        m_gen = (m_gen + 1) % 65536;
      end
`ifdef LIFE_SEQ_WATCHDOG_EN
      if (m_state >= 2 && nxt == m_state && m_age + 1 >= int'(WD)) begin
        nxt = 0;
        m_err = 1'b1;
      end
`endif
      m_age   = (nxt == m_state) ? m_age + 1 : 0;
      m_state = nxt;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", 32'(state), 32'(m_state));
      chk("busy", 32'(busy), 32'(m_state != 0));
      chk("gen_count", 32'(gen_count), 32'(m_gen));
      chk("error", 32'(error), 32'(m_err));
      chk("init_start", 32'(init_start), 32'(rst_n && m_state == 2 && m_age == 0));
      chk("update_start", 32'(update_start), 32'(rst_n && m_state == 3 && m_age == 0));
      chk("copy_start", 32'(copy_start), 32'(rst_n && m_state == 4 && m_age == 0));
    end
  end

  initial begin
    // Reset and boot reseed
    tick();
    cmp_en = 1'b1;
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd2);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_init_start", 32'(init_start), 32'd0);
    chk("rst_gen", 32'(gen_count), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("boot_init_start", 32'(init_start), 32'd1);
    tick();
    chk("boot_init_start_drop", 32'(init_start), 32'd0);
    repeat (9) tick();
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    chk("boot_idle_state", 32'(state), 32'd0);
    chk("boot_idle_busy", 32'(busy), 32'd0);
    chk("boot_idle_gen", 32'(gen_count), 32'd0);

    // Free run at 20 Hz: 100 idle cycles then the update/copy pair
    run = 1'b1; speed = 2'd3; vsync = 1'b1;
    repeat (99) tick();
    chk("run_99_idle", 32'(state), 32'd0);
    tick();
    chk("run_100_waitvs", 32'(state), 32'd1);
    run = 1'b0;
    tick();
    chk("run_update_state", 32'(state), 32'd3);
    chk("run_update_start", 32'(update_start), 32'd1);
    update_done = 1'b1;
    tick();
    update_done = 1'b0;
    chk("run_copy_start", 32'(copy_start), 32'd1);
    copy_done = 1'b1;
    tick();
    copy_done = 1'b0;
    chk("run_gen1", 32'(gen_count), 32'd1);

    // Step held off by vsync, with a second step ignored
    vsync = 1'b0; step = 1'b1;
    tick();
    step = 1'b0;
    repeat (25) tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (24) tick();
    chk("step_waitvs_hold", 32'(state), 32'd1);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("step_update_start", 32'(update_start), 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_busy_ignored", 32'(state), 32'd3);
    update_done = 1'b1;
    tick();
    update_done = 1'b0;
    copy_done = 1'b1;
    tick();
    copy_done = 1'b0;
    chk("step_gen2", 32'(gen_count), 32'd2);

    // Five zero-length generations back to back, then a reseed
    step = 1'b1; vsync = 1'b1; update_done = 1'b1; copy_done = 1'b1;
    repeat (20) tick();
    step = 1'b0; vsync = 1'b0; update_done = 1'b0; copy_done = 1'b0;
    chk("burst_gen7", 32'(gen_count), 32'd7);
    randomize = 1'b1; step = 1'b1; vsync = 1'b1;
    tick();
    step = 1'b0;
    tick();
    randomize = 1'b0; vsync = 1'b0;
    chk("reseed_init_start", 32'(init_start), 32'd1);
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    chk("reseed_gen0", 32'(gen_count), 32'd0);
    copy_done = 1'b1;
    tick();
    copy_done = 1'b0;
    chk("stray_copy_state", 32'(state), 32'd0);
    chk("stray_copy_gen", 32'(gen_count), 32'd0);

    // Counter wrap from 0xFFFF
    force dut.gen_count_q = 16'hFFFF;
    m_gen = 65535;
    tick();
    release dut.gen_count_q;
    step = 1'b1; vsync = 1'b1; update_done = 1'b1; copy_done = 1'b1;
    repeat (4) tick();
    step = 1'b0; vsync = 1'b0; update_done = 1'b0; copy_done = 1'b0;
    chk("wrap_gen0", 32'(gen_count), 32'd0);

    // Speed change mid-interval keeps the running timer
    run = 1'b1; speed = 2'd0;
    repeat (50) tick();
    speed = 2'd3;
    repeat (49) tick();
    chk("speed_chg_idle", 32'(state), 32'd0);
    tick();
    chk("speed_chg_waitvs", 32'(state), 32'd1);
    run = 1'b0; vsync = 1'b1;
    tick();
    vsync = 1'b0;

    // Withheld update_done
    repeat (63) tick();
    chk("wdog_cycle64_state", 32'(state), 32'd3);
    tick();
`ifdef LIFE_SEQ_WATCHDOG_EN
    chk("wdog_timeout_state", 32'(state), 32'd0);
    chk("wdog_timeout_error", 32'(error), 32'd1);
`else
    chk("wdog_none_state", 32'(state), 32'd3);
    chk("wdog_none_error", 32'(error), 32'd0);
`endif
    repeat (10) tick();

    // Reset mid-phase aborts with no copy
    rst_n = 1'b0;
    tick();
    chk("abort_state", 32'(state), 32'd2);
    chk("abort_copy_start", 32'(copy_start), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_boot_init_start", 32'(init_start), 32'd1);
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    chk("abort_idle", 32'(state), 32'd0);
    repeat (3) tick();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
